insert_parity: RTL and testbench
================================

INSERT_PARITY -- requirements
Module: insert_parity

Interface
REQ-001 SHALL have parameter WORDS, default 5: number of packed words per beat.
REQ-002 SHALL have parameter BITS_PER_WORD, default 9: data bits per word, excluding parity.
REQ-003 SHALL have parameter ODD_PARITY, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port din  input  BITS_PER_WORD*WORDS  packed data; word i occupies [(i+1)*B-1 : i*B].
REQ-007 SHALL have port din_valid  input  1  din holds a beat.
REQ-008 SHALL have port din_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port inject_err  input  WORDS  per-word parity inversion, sampled with each accepted beat.
REQ-010 SHALL have port dout  output  (BITS_PER_WORD+1)*WORDS  packed slots; slot i occupies [(i+1)*(B+1)-1 : i*(B+1)].
REQ-011 SHALL have port dout_valid  output  1  dout holds a beat.
REQ-012 SHALL have port dout_ready  input  1  downstream accepts dout this cycle.
REQ-013 SHALL have port beat_count  output  16  number of beats delivered downstream, saturating.

Function
REQ-014 Slot i SHALL carry word i unchanged in bits [(i+1)*(B+1)-2 : i*(B+1)] and its parity bit in bit (i+1)*(B+1)-1, the slot MSB.
REQ-015 Parity SHALL be the XOR of the word's bits for ODD_PARITY=0 and its inverse for ODD_PARITY=1, then XORed with inject_err[i].
REQ-016 A beat SHALL be accepted when din_valid and din_ready are both high; dout SHALL be delivered when dout_valid and dout_ready are both high.
REQ-017 The data path SHALL be a registered output stage plus a one-entry skid register; dout and dout_valid SHALL come directly from flops.
REQ-018 Latency SHALL be 1 cycle: a beat accepted at edge N appears on dout after edge N when the output stage is empty or draining.
REQ-019 With dout_ready held high, throughput SHALL be one beat per cycle with no bubbles.
REQ-020 din_ready SHALL be a registered signal that is low exactly while the skid register is occupied.
REQ-021 When the output stage is stalled (dout_valid=1, dout_ready=0) and a beat is accepted, that beat SHALL enter the skid register; din_ready SHALL drop on the next cycle.
REQ-022 When the output drains while the skid register is full, the skid beat SHALL move to the output stage on that edge and din_ready SHALL rise on the next cycle.
REQ-023 Simultaneous accept and deliver with the skid register empty SHALL load the new beat into the output stage with dout_valid remaining 1.
REQ-024 dout and dout_valid SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-025 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-026 beat_count SHALL increment on each delivered beat and hold at 16'hFFFF.
REQ-027 Parity SHALL be computed before the beat is registered; the skid register SHALL store already-encoded slots.

Reset
REQ-028 rst_n low SHALL asynchronously clear dout_valid, the skid-occupied flag, dout (all zeros) and beat_count.
REQ-029 din_ready SHALL be 0 during reset and SHALL become 1 on the first rising clk after rst_n deasserts.
REQ-030 Reset asserted mid-transfer SHALL discard both the output-stage beat and the skid beat.

Structure
REQ-031 A shared package SHALL hold the slot-width constant (BITS_PER_WORD+1) and a parity function taking the word, the odd flag and the inject bit.
REQ-032 Per-word encoding SHALL be a generate loop over WORDS; the output stage plus skid register SHALL be the single sub-module parity_skid_reg, parameterised by total width.

Verification
REQ-033 Even parity, WORDS=5, B=9: din word0=9'h001, others 0, dout_ready=1 -> slot0=10'h201, slots1-4=10'h000, one cycle after accept.
REQ-034 ODD_PARITY=1: same stimulus -> slot0=10'h001, slots1-4=10'h200; with inject_err=5'b00001 -> slot0=10'h201.
REQ-035 Stream 8 beats with dout_ready=0 after the first -> din_ready low after the second beat, exactly 2 beats held; release -> all 8 delivered in order, then beat_count=8.
REQ-036 Random valid/ready toggling over 10,000 beats -> output equals the scoreboard model, with no loss or duplication.
REQ-037 Assert rst_n low with both stages full -> dout_valid=0, beat_count=0 immediately; din_ready=1 on the first edge after release.
REQ-038 Preload beat_count near saturation by delivering 65,540 beats -> beat_count holds at 16'hFFFF.

Source files
------------

// File: rtl/insert_parity_pkg.sv
// Shared constants and the per-word parity helper for the parity inserter.
package insert_parity_pkg;

  // Widest data word the parity helper accepts; narrower words are zero-extended,
  // which leaves their XOR unchanged.
  localparam int MAX_WORD_BITS = 64;

  // One parity bit is appended above every data word.
  function automatic int parity_slot_width(input int bits_per_word);
    return bits_per_word + 1;
  endfunction

  // Even parity is the XOR of the word. Odd parity is its inverse. A set inject
  // bit flips the result to force a detectable error downstream.
  function automatic logic parity_bit(input logic [MAX_WORD_BITS-1:0] word,
                                      input logic                     odd,
                                      input logic                     inject);
    return (^word) ^ odd ^ inject;
  endfunction

endpackage

// File: rtl/insert_parity_skid_reg.sv
// Output register plus one-entry skid buffer. Downstream sees data and valid
// straight from flops, and upstream sees a registered ready.
module parity_skid_reg #(
  parameter int WIDTH = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             deliver;

  assign accept  = valid_i & ready_q;
  assign deliver = out_valid_q & ready_i;

  // Next-state selection: refill the output stage from skid first, then from input.
  always_comb begin
    // NOTE: every output of this block gets its hold value first, so no path infers a latch.
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || deliver) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = data_i;
      skid_valid_d = 1'b1;
    end
    ready_d = ~skid_valid_d;
  end

  // State registers. Ready stays low in reset and rises on the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are cleared too, so dout reads all zeros out of reset.
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values.
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = out_data_q;
  assign valid_o = out_valid_q;

endmodule

// File: rtl/insert_parity.sv
// Appends a parity bit to every packed word. The encoded beat then passes through
// a registered skid stage, and delivered beats are counted with saturation.
module insert_parity
  import insert_parity_pkg::*;
#(
  parameter int WORDS         = 5,
  parameter int BITS_PER_WORD = 9,
  parameter int ODD_PARITY    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [BITS_PER_WORD*WORDS-1:0]   din,
  input  logic                             din_valid,
  output logic                             din_ready,
  input  logic [WORDS-1:0]                 inject_err,
  output logic [(BITS_PER_WORD+1)*WORDS-1:0] dout,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic [15:0]                      beat_count
);

  localparam int SLOT = parity_slot_width(BITS_PER_WORD);
  localparam int DW   = SLOT * WORDS;

  logic [DW-1:0] encoded;
  logic [15:0]   count_q, count_d;

  // Encode each word before registering it, so the skid buffer holds finished slots.
  for (genvar i = 0; i < WORDS; i++) begin : g_word
    logic [MAX_WORD_BITS-1:0] word_ext;
    assign word_ext = MAX_WORD_BITS'(din[i*BITS_PER_WORD +: BITS_PER_WORD]);
    assign encoded[i*SLOT +: SLOT] =
      {parity_bit(word_ext, ODD_PARITY != 0, inject_err[i]),
       din[i*BITS_PER_WORD +: BITS_PER_WORD]};
  end

  parity_skid_reg #(
    .WIDTH (DW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (encoded),
    .valid_i (din_valid),
    .ready_o (din_ready),
    .data_o  (dout),
    .valid_o (dout_valid),
    .ready_i (dout_ready)
  );

  // Count delivered beats, holding at the all-ones ceiling.
  always_comb begin
    count_d = count_q;
    if (dout_valid && dout_ready && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign beat_count = count_q;

endmodule

// File: tb/tb_insert_parity.sv
// Randomised bench for insert_parity. It drives an even-parity and an odd-parity
// instance from the same stimulus and compares both against a queue-based model.
module tb_insert_parity;

  localparam int WORDS = 5;
  localparam int B     = 9;
  localparam int IW    = B * WORDS;
  localparam int DW    = (B + 1) * WORDS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [IW-1:0]   din;
  logic            din_valid;
  logic [WORDS-1:0] inject_err;
  logic            dout_ready;

  logic            din_ready, din_ready_odd;
  logic [DW-1:0]   dout, dout_odd;
  logic            dout_valid, dout_valid_odd;
  logic [15:0]     beat_count, beat_count_odd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  insert_parity #(.WORDS(WORDS), .BITS_PER_WORD(B), .ODD_PARITY(0)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .inject_err(inject_err), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .beat_count(beat_count));

  insert_parity #(.WORDS(WORDS), .BITS_PER_WORD(B), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready_odd),
    .inject_err(inject_err), .dout(dout_odd), .dout_valid(dout_valid_odd),
    .dout_ready(dout_ready), .beat_count(beat_count_odd));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: count the ones in each word and place the parity bit above it.
  function automatic logic [DW-1:0] encode(input logic [IW-1:0] d,
                                           input logic [WORDS-1:0] inj, input bit odd);
    logic [DW-1:0] r;
    logic [B-1:0]  w;
    bit            p;
    r = '0;
    for (int i = 0; i < WORDS; i++) begin
      w = d[i*B +: B];
      p = (($countones(w) % 2) == 1);
      p = p ^ odd ^ inj[i];
      r[i*(B+1) +: B+1] = {p, w};
    end
    return r;
  endfunction

  typedef struct {
    logic [DW-1:0] ev;
    logic [DW-1:0] od;
  } exp_t;

  exp_t exp_q[$];
  int   cnt_m;
  bit   seen_edge;

  // Model and compare process. Outputs are checked on the falling edge. The model
  // then applies the handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cnt_m     = 0;
      seen_edge = 0;
      check("rst_dout_valid", dout_valid, 0);
      check("rst_din_ready", din_ready, 0);
      check("rst_beat_count", beat_count, 0);
    end else begin
      check("din_ready", din_ready, seen_edge ? (exp_q.size() < 2) : 1'b0);
      check("din_ready_odd", din_ready_odd, seen_edge ? (exp_q.size() < 2) : 1'b0);
      check("dout_valid", dout_valid, exp_q.size() > 0);
      check("dout_valid_odd", dout_valid_odd, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("dout_even", dout, exp_q[0].ev);
        check("dout_odd", dout_odd, exp_q[0].od);
      end
      check("beat_count", beat_count, cnt_m);
      check("beat_count_odd", beat_count_odd, cnt_m);
      if (dout_valid && dout_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (cnt_m < 16'hFFFF) cnt_m++;
      end
      if (din_valid && din_ready) begin
        exp_q.push_back('{ev: encode(din, inject_err, 0), od: encode(din, inject_err, 1)});
      end
      seen_edge = 1;
    end
  end

  // Advance one cycle. Report whether the current beat is taken on that edge.
  task automatic step(output bit took);
    took = din_valid && din_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit t;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(t);
  endtask

  logic [IW-1:0] sb [8];
  int            idx;
  int            n;
  int            c;
  bit            took;

  initial begin
    din = '0; din_valid = 0; inject_err = '0; dout_ready = 0; rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("ready_before_first_edge", din_ready, 0);
    step(took);
    check("ready_first_edge", din_ready, 1);
    check("reset_dout_zero", dout, 0);

    // Hand-computed slot values
    dout_ready = 1; din = IW'(1); din_valid = 1;
    step(took);
    din_valid = 0;
    check("lit_accept", took, 1);
    check("lit_even_slot0", dout[9:0], 10'h201);
    check("lit_even_hi", dout[DW-1:10], 0);
    check("lit_odd_slot0", dout_odd[9:0], 10'h001);
    check("lit_odd_hi", dout_odd[DW-1:10], {4{10'h200}});
    step(took);
    inject_err = 5'b00001; din_valid = 1;
    step(took);
    din_valid = 0; inject_err = '0;
    check("lit_inj_odd_slot0", dout_odd[9:0], 10'h201);
    check("lit_inj_even_slot0", dout[9:0], 10'h001);
    step(took);

    // Stall: only two beats can be held
    do_reset();
    dout_ready = 0;
    for (int i = 0; i < 8; i++) sb[i] = IW'({$urandom(), $urandom()});
    idx = 0; din = sb[0]; din_valid = 1;
    for (int k = 0; k < 6; k++) begin
      step(took);
      if (took) begin idx++; din = sb[idx]; end
    end
    check("stall_held", idx, 2);
    check("stall_ready_low", din_ready, 0);
    check("stall_valid", dout_valid, 1);
    dout_ready = 1;
    c = 0;
    while (idx < 8 && c < 40) begin
      step(took);
      if (took) begin idx++; if (idx < 8) din = sb[idx]; else din_valid = 0; end
      c++;
    end
    check("stall_all_accepted", idx, 8);
    din_valid = 0;
    c = 0;
    while (dout_valid && c < 10) begin step(took); c++; end
    check("stall_drained", dout_valid, 0);
    check("stall_beat_count", beat_count, 8);

    // Random valid/ready traffic
    n = 0; c = 0; took = 0; din_valid = 0;
    while (n < 10000 && c < 40000) begin
      if (!din_valid || took) begin
        din_valid  = ($urandom() % 8) != 0;
        din        = IW'({$urandom(), $urandom()});
        inject_err = WORDS'($urandom());
      end
      dout_ready = ($urandom() % 8) != 0;
      step(took);
      if (took) n++;
      c++;
    end
    check("random_beats", n, 10000);
    din_valid = 0; dout_ready = 1;
    repeat (4) step(took);
    check("random_drained", dout_valid, 0);

    // Reset with both stages full
    dout_ready = 0; din_valid = 1; c = 0;
    while (din_ready && c < 10) begin
      step(took);
      din = IW'({$urandom(), $urandom()});
      c++;
    end
    check("full_ready_low", din_ready, 0);
    check("full_valid", dout_valid, 1);
    rst_n = 0;
    #1;
    check("midrst_dout_valid", dout_valid, 0);
    check("midrst_beat_count", beat_count, 0);
    check("midrst_dout", dout, 0);
    din_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    check("midrst_ready_pre", din_ready, 0);
    step(took);
    check("midrst_ready_post", din_ready, 1);

    // Saturation of the beat counter
    dout_ready = 1; din_valid = 1; din = IW'({$urandom(), $urandom()});
    repeat (65545) step(took);
    check("sat_beat_count", beat_count, 16'hFFFF);
    din_valid = 0;
    repeat (3) step(took);
    check("sat_hold", beat_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
